// File: rtl/key_mix_sl_pkg.sv
// Shared key-schedule definitions: default word/array sizes, RC5 magic
// constants, mixer state encoding and a width-W left-rotate helper.
package key_mix_sl_pkg;

    localparam int W = 32;
    localparam int T = 26;
    localparam int C = 4;

    localparam logic [W-1:0] P_W = 32'hB7E1_5163;
    localparam logic [W-1:0] Q_W = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX_S = 2'd1,
        MIX_L = 2'd2,
        FIN   = 2'd3
    } mix_state_t;

    // Rotate left by amount; the doubled word makes amount 0 fall out naturally.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] value,
                                          input logic [$clog2(W)-1:0] amount);
        logic [2*W-1:0] dbl;
        dbl = {value, value} << amount;
        return dbl[2*W-1:W];
    endfunction

endpackage

// File: rtl/key_mix_sl_rotl.sv
// key_mix_rotl: w-bit barrel left-rotator with an lgw-bit rotate amount.
module key_mix_rotl #(
    parameter int w   = 32,
    parameter int lgw = $clog2(w)
) (
    input  logic [w-1:0]   value,
    input  logic [lgw-1:0] amount,
    output logic [w-1:0]   result
);

    logic [2*w-1:0] dbl;

    // Shift a doubled copy so the bits leaving the top re-enter at the bottom.
    always_comb begin
        dbl    = {value, value} << amount;
        result = dbl[2*w-1:w];
    end

endmodule

// File: rtl/key_mix_sl.sv
// key_mix_sl: RC5/RC6 three-pass key-schedule mix over external S and L
// memories (combinational read, single write strobe each).
// Optional macro KEY_MIX_AB_OUT_EN adds A_dbg/B_dbg mirrors of the A/B registers.
//
// state | meaning
// IDLE  | waiting for start; done holds the result of the last mix
// MIX_S | S[i] <= rotl(S[i]+A+B, 3), A latches the new word
// MIX_L | L[j] <= rotl(L[j]+A+B, A+B), B latches the new word, advance i/j/k
// FIN   | one-cycle wrap-up that raises done
module key_mix_sl
    import key_mix_sl_pkg::*;
#(
    parameter int w = W,
    parameter int t = T,
    parameter int c = C,
    localparam int t_length = $clog2(t),
    localparam int c_length = (c > 1) ? $clog2(c) : 1,
    localparam int lgw      = $clog2(w),
    localparam int n_iter   = 3 * ((t > c) ? t : c),
    localparam int k_length = $clog2(n_iter)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [w-1:0]        S_rdata,
    input  logic [w-1:0]        L_rdata,
    output logic [t_length-1:0] S_address,
    output logic [w-1:0]        S_wdata,
    output logic                S_we,
    output logic [c_length-1:0] L_address,
    output logic [w-1:0]        L_wdata,
    output logic                L_we,
    output logic                busy,
    output logic                done
`ifdef KEY_MIX_AB_OUT_EN
    ,
    output logic [w-1:0]        A_dbg,
    output logic [w-1:0]        B_dbg
`endif
);

    mix_state_t state, state_nx;

    logic [w-1:0]        a_reg, b_reg;
    logic [w-1:0]        sum_a, sum_b, tmp_a, tmp_b;
    logic [lgw-1:0]      rot_amt;
    logic [t_length-1:0] i_idx;
    logic [c_length-1:0] j_idx;
    logic [k_length-1:0] k_cnt;
    logic                done_reg;

    // Both sums see the registered A; in MIX_L that is the word just written to S.
    always_comb begin
        sum_a   = S_rdata + a_reg + b_reg;
        sum_b   = L_rdata + a_reg + b_reg;
        rot_amt = lgw'(a_reg + b_reg);
    end

    key_mix_rotl #(.w(w), .lgw(lgw)) u_rotl_s (
        .value  (sum_a),
        .amount (lgw'(3)),
        .result (tmp_a)
    );

    key_mix_rotl #(.w(w), .lgw(lgw)) u_rotl_l (
        .value  (sum_b),
        .amount (rot_amt),
        .result (tmp_b)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Datapath registers: A/B accumulators, i/j/k indices and the done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            k_cnt    <= '0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= '0;
                        b_reg    <= '0;
                        i_idx    <= '0;
                        j_idx    <= '0;
                        k_cnt    <= '0;
                        done_reg <= 1'b0;
                    end
                end
                MIX_S: a_reg <= tmp_a;
                MIX_L: begin
                    b_reg <= tmp_b;
                    i_idx <= (i_idx == t_length'(t - 1)) ? '0 : i_idx + 1'b1;
                    j_idx <= (j_idx == c_length'(c - 1)) ? '0 : j_idx + 1'b1;
                    k_cnt <= k_cnt + 1'b1;
                end
                FIN:     done_reg <= 1'b1;
                default: ;
            endcase
        end
    end

    // Next state and write strobes; write data is zero whenever not writing.
    always_comb begin
        state_nx = state;
        S_we     = 1'b0;
        L_we     = 1'b0;
        S_wdata  = '0;
        L_wdata  = '0;
        busy     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = MIX_S;
            MIX_S: begin
                busy     = 1'b1;
                S_we     = 1'b1;
                S_wdata  = tmp_a;
                state_nx = MIX_L;
            end
            MIX_L: begin
                busy     = 1'b1;
                L_we     = 1'b1;
                L_wdata  = tmp_b;
                state_nx = (k_cnt == k_length'(n_iter - 1)) ? FIN : MIX_S;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign S_address = i_idx;
    assign L_address = j_idx;
    assign done      = done_reg;

`ifdef KEY_MIX_AB_OUT_EN
    assign A_dbg = a_reg;
    assign B_dbg = b_reg;
`else
    // A/B debug taps not built.
`endif

endmodule

// File: tb/tb_key_mix_sl.sv
// Bench for key_mix_sl: behavioural S/L memories, write log, RC5 reference mix.
module tb_key_mix_sl;

    localparam int TW = 26;
    localparam int TC = 4;
    localparam int NI = 78;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] S_rdata, L_rdata;
    logic [4:0]  S_address;
    logic [31:0] S_wdata;
    logic        S_we;
    logic [1:0]  L_address;
    logic [31:0] L_wdata;
    logic        L_we;
    logic        busy, done;

    key_mix_sl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .S_rdata   (S_rdata),
        .L_rdata   (L_rdata),
        .S_address (S_address),
        .S_wdata   (S_wdata),
        .S_we      (S_we),
        .L_address (L_address),
        .L_wdata   (L_wdata),
        .L_we      (L_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [31:0] s_mem [32];
    logic [31:0] l_mem [4];
    logic [31:0] s_init [32];
    logic [31:0] l_init [4];
    logic [31:0] s_ref [26];
    logic [31:0] l_ref [4];
    bit          load = 1'b0;

    assign S_rdata = s_mem[S_address];
    assign L_rdata = l_mem[L_address];

    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 32; x++) s_mem[x] <= s_init[x];
            for (int x = 0; x < 4; x++)  l_mem[x] <= l_init[x];
        end else begin
            if (S_we) s_mem[S_address] <= S_wdata;
            if (L_we) l_mem[L_address] <= L_wdata;
        end
    end

    typedef struct {
        bit          is_l;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t wlog[$];
    int  both_cnt = 0;

    always @(negedge clk) begin
        if (S_we && L_we) both_cnt++;
        if (S_we) wlog.push_back('{1'b0, int'(S_address), S_wdata});
        if (L_we) wlog.push_back('{1'b1, int'(L_address), L_wdata});
    end

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int m;
        m = n & 31;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    // Reference RC5 mix starting from s_init/l_init.
    task automatic run_model;
        logic [31:0] a, b;
        int ii, jj;
        for (int x = 0; x < TW; x++) s_ref[x] = s_init[x];
        for (int x = 0; x < TC; x++) l_ref[x] = l_init[x];
        a = 0; b = 0; ii = 0; jj = 0;
        for (int k = 0; k < NI; k++) begin
            a = rl(s_ref[ii] + a + b, 3);
            s_ref[ii] = a;
            b = rl(l_ref[jj] + a + b, int'((a + b) & 32'd31));
            l_ref[jj] = b;
            ii = (ii + 1) % TW;
            jj = (jj + 1) % TC;
        end
    endtask

    task automatic cmp_arrays(input string tag);
        for (int x = 0; x < TW; x++) chk($sformatf("%s_S[%0d]", tag, x), s_mem[x], s_ref[x]);
        for (int x = 0; x < TC; x++) chk($sformatf("%s_L[%0d]", tag, x), l_mem[x], l_ref[x]);
    endtask

    task automatic load_mem;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    // Caller is at a negedge. Pulses start, then observes once per cycle.
    task automatic run_mix(input int inject_at, input int rst_at,
                           output int busy_cnt, output int done_at, output logic done_after);
        busy_cnt = 0;
        done_at  = -1;
        wlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_after = done;
        for (int n = 0; n < 400; n++) begin
            if (n == rst_at) begin
                rst = 1'b0;
                #1;
                chk("midrst_busy", {31'b0, busy}, 32'd0);
                chk("midrst_S_we", {31'b0, S_we}, 32'd0);
                chk("midrst_L_we", {31'b0, L_we}, 32'd0);
                chk("midrst_done", {31'b0, done}, 32'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (done) begin
                done_at = n;
                break;
            end
            if (busy) busy_cnt++;
            if (n == inject_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    wr_t exp_first [4];
    int  bc, da, nz, bad_addr, si, li, both0;
    logic dn;

    initial begin
        exp_first[0] = '{1'b0, 0, 32'h0000_0008};
        exp_first[1] = '{1'b1, 0, 32'h0000_0800};
        exp_first[2] = '{1'b0, 1, 32'h0000_4040};
        exp_first[3] = '{1'b1, 1, 32'h0000_4840};

        for (int x = 0; x < 32; x++) s_init[x] = '0;
        for (int x = 0; x < 4; x++)  l_init[x] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy",    {31'b0, busy}, 32'd0);
        chk("rst_done",    {31'b0, done}, 32'd0);
        chk("rst_S_we",    {31'b0, S_we}, 32'd0);
        chk("rst_L_we",    {31'b0, L_we}, 32'd0);
        chk("rst_S_wdata", S_wdata, 32'd0);
        chk("rst_L_wdata", L_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // All-zero arrays: every written word stays zero; latency and index wrap.
        load_mem();
        both0 = both_cnt;
        run_mix(-1, -1, bc, da, dn);
        chk("zero_busy_cycles", bc, 156);
        chk("zero_done_at", da, 157);
        chk("zero_write_count", wlog.size(), 2 * NI);
        nz = 0; bad_addr = 0; si = 0; li = 0;
        foreach (wlog[e]) begin
            if (wlog[e].data != 0) nz++;
            if (wlog[e].is_l != e[0]) bad_addr++;
            if (wlog[e].is_l) begin
                if (wlog[e].addr != li % TC) bad_addr++;
                li++;
            end else begin
                if (wlog[e].addr != si % TW) bad_addr++;
                si++;
            end
        end
        chk("zero_nonzero_writes", nz, 0);
        chk("zero_addr_sequence", bad_addr, 0);
        chk("zero_L_iterations", li, NI);
        chk("zero_S25_then_S0", {wlog[2*25].addr, wlog[2*26].addr}, {32'd25, 32'd0});
        chk("zero_both_we", both_cnt - both0, 0);

        // S[0]=1: first four writes against the hand-worked table, then full arrays.
        s_init[0] = 32'd1;
        load_mem();
        run_mix(-1, -1, bc, da, dn);
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("first_wr%0d_kind", v), {31'b0, wlog[v].is_l}, {31'b0, exp_first[v].is_l});
            chk($sformatf("first_wr%0d_addr", v), wlog[v].addr, exp_first[v].addr);
            chk($sformatf("first_wr%0d_data", v), wlog[v].data, exp_first[v].data);
        end
        run_model();
        cmp_arrays("s0one");

        // Same input with a stray start at cycle 10 while busy: nothing changes.
        load_mem();
        run_mix(10, -1, bc, da, dn);
        chk("inject_done_cleared", {31'b0, dn}, 32'd0);
        chk("inject_busy_cycles", bc, 156);
        chk("inject_done_at", da, 157);
        cmp_arrays("inject");

        // Start in the very cycle done is seen: done drops next edge, mix restarts.
        for (int x = 0; x < TW; x++) s_init[x] = s_mem[x];
        for (int x = 0; x < TC; x++) l_init[x] = l_mem[x];
        run_model();
        chk("pre_restart_done", {31'b0, done}, 32'd1);
        run_mix(-1, -1, bc, da, dn);
        chk("restart_done_cleared", {31'b0, dn}, 32'd0);
        chk("restart_done_at", da, 157);
        cmp_arrays("restart");

        // RC5-32/12/16 with a random key, with a reset at cycle 40 of the first attempt.
        s_init[0] = 32'hB7E1_5163;
        for (int x = 1; x < TW; x++) s_init[x] = s_init[x-1] + 32'h9E37_79B9;
        for (int x = 0; x < TC; x++) l_init[x] = $urandom;
        load_mem();
        run_mix(-1, 40, bc, da, dn);
        load_mem();
        run_mix(-1, -1, bc, da, dn);
        chk("replay_first_addr", wlog[0].addr, 0);
        chk("replay_first_data", wlog[0].data, rl(32'hB7E1_5163, 3));
        chk("replay_done_at", da, 157);
        run_model();
        cmp_arrays("rc5");
        chk("never_both_we", both_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
